// File: rtl/fsmc_fifo_regs_pkg.sv
// Register map, CTRL bit indices and STATUS bit positions shared by the FIFO
// register block and anything that talks to it.
package fsmc_fifo_regs_pkg;

    localparam logic [7:0] REG_FIFO_DATA   = 8'h10;
    localparam logic [7:0] REG_FIFO_STATUS = 8'h11;
    localparam logic [7:0] REG_FIFO_CTRL   = 8'h12;
    localparam logic [7:0] REG_FIFO_PEAK   = 8'h13;

    localparam int unsigned CTRL_FLUSH = 0;
    localparam int unsigned CTRL_CLEAR = 1;

    // STATUS layout for the 16-bit bus: {ovf, unf, full, empty, 0.., count}
    localparam int unsigned STAT_OVF   = 15;
    localparam int unsigned STAT_UNF   = 14;
    localparam int unsigned STAT_FULL  = 13;
    localparam int unsigned STAT_EMPTY = 12;

endpackage

// File: rtl/fsmc_fifo_regs_if.sv
// Strobe/address/data bundle between clocked_bus_slave (master) and a register target (slave).
interface fsmc_fifo_regs_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
);
    logic          do_write;
    logic [AW-1:0] w_adr;
    logic [DW-1:0] w_data;
    logic          do_read;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] read_data;

    modport master (output do_write, w_adr, w_data, do_read, r_adr, input read_data);
    modport slave  (input do_write, w_adr, w_data, do_read, r_adr, output read_data);
endinterface

// File: rtl/fsmc_fifo_regs_sync_fifo.sv
// Synchronous FIFO with a show-ahead head register so the current head is
// always available from a flop; push/pop must already be qualified by the caller.
module sync_fifo #(
    parameter int unsigned DW         = 16,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DW-1:0]         din,
    output logic [DW-1:0]         head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [DW-1:0]         mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_next;

    assign rd_next = pop ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= mem[0];
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            rd_ptr <= rd_next;
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            // A word written into the slot that becomes the head bypasses the array.
            head <= (push && (wr_ptr == rd_next)) ? din : mem[rd_next];
        end
    end

endmodule

// File: rtl/fsmc_fifo_regs.sv
// FIFO register target behind clocked_bus_slave: DATA push/pop, STATUS, CTRL and
// PEAK registers, with level and flags also exported for LEDs.
module fsmc_fifo_regs
    import fsmc_fifo_regs_pkg::*;
#(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 16,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fsmc_fifo_regs_if.slave      bus,
    output logic [DEPTH_LOG2:0]  fifo_count,
    output logic                 fifo_full,
    output logic                 fifo_empty
);
    localparam int unsigned CW = DEPTH_LOG2 + 1;

    logic          wr_data, wr_ctrl, rd_data;
    logic          push, pop, flush, clr;
    logic          ovf_evt, unf_evt;
    logic          ovf, unf;
    logic [CW-1:0] peak, count_next;
    logic [DW-1:0] head, status, rd_mux;

    assign wr_data = bus.do_write && (bus.w_adr == AW'(REG_FIFO_DATA));
    assign wr_ctrl = bus.do_write && (bus.w_adr == AW'(REG_FIFO_CTRL));
    assign rd_data = bus.do_read  && (bus.r_adr == AW'(REG_FIFO_DATA));

    // Pop is evaluated first so a push into a full FIFO succeeds when it is drained in the same cycle.
    assign pop     = rd_data && !fifo_empty;
    assign push    = wr_data && (!fifo_full || pop);
    assign flush   = wr_ctrl && bus.w_data[CTRL_FLUSH];
    assign clr     = wr_ctrl && bus.w_data[CTRL_CLEAR];
    assign ovf_evt = wr_data && fifo_full && !pop;
    assign unf_evt = rd_data && fifo_empty;

    sync_fifo #(.DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (bus.w_data),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        count_next = fifo_count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = fifo_count + CW'(1);
        end else if (pop && !push) begin
            count_next = fifo_count - CW'(1);
        end
    end

    // Clear first, then the same cycle's events re-set what they touch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf  <= 1'b0;
            unf  <= 1'b0;
            peak <= '0;
        end else if (clr) begin
            ovf  <= ovf_evt;
            unf  <= unf_evt;
            peak <= count_next;
        end else begin
            if (ovf_evt) ovf <= 1'b1;
            if (unf_evt) unf <= 1'b1;
            if (count_next > peak) peak <= count_next;
        end
    end

    always_comb begin
        status             = '0;
        status[STAT_OVF]   = ovf;
        status[STAT_UNF]   = unf;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[CW-1:0]     = fifo_count;

        rd_mux = '0;
        if (bus.r_adr == AW'(REG_FIFO_DATA)) begin
            rd_mux = fifo_empty ? '0 : head;
        end else if (bus.r_adr == AW'(REG_FIFO_STATUS)) begin
            rd_mux = status;
        end else if (bus.r_adr == AW'(REG_FIFO_PEAK)) begin
            rd_mux = DW'(peak);
        end
    end

    assign bus.read_data = rd_mux;

endmodule
